stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that merges `NUM_IN` first-word fall-through (FWFT) source streams into one downstream write port, normally the write side of a relay station. It bounds each grant to a configurable burst length. It tags every output word with its source index so that a consumer can demultiplex. The output stage is registered so the block can be floorplanned away from its sources.

## Interface
Parameters:
- `NUM_IN`, 4: number of source streams; legal range 1..16.
- `DATA_WIDTH`, 32: width of one data word.
- `MAX_BURST`, 8: maximum beats transferred per grant; legal range 1..256.
- `ID_WIDTH`, `NUM_IN > 1 ? $clog2(NUM_IN) : 1`: width of the source tag.

Ports:
- `clk`  input  1  single clock; all logic is rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `in_empty_n`  input  NUM_IN  per-source FWFT valid; bit i set means `in_dout` slice i holds a word.
- `in_read`  output  NUM_IN  per-source pop strobe; one-hot or zero.
- `in_dout`  input  NUM_IN*DATA_WIDTH  source words; slice i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_full_n`  input  1  downstream not-almost-full.
- `out_write`  output  1  registered write strobe to downstream.
- `out_din`  output  DATA_WIDTH  registered data word.
- `out_id`  output  ID_WIDTH  registered source index of `out_din`.
- `busy`  output  1  high while in GRANT.

## Operation
- State machine with two states, IDLE and GRANT. Held registers:
  - `gnt` (ID_WIDTH): current grant.
  - `last` (ID_WIDTH): most recent grant.
  - `beats` ($clog2(MAX_BURST+1) bits): beats moved in the current grant.
- IDLE:
  - If any `in_empty_n` bit is set, `gnt` takes the first set index searching `last+1`, `last+2`, … with wrap modulo NUM_IN.
  - In the same cycle: `last <= gnt`, `beats <= 0`, go to GRANT.
  - If no bit is set, stay in IDLE.
  - IDLE never pops a source.
- GRANT:
  - Combinational `in_read[gnt] = in_empty_n[gnt] & out_full_n`; all other bits are 0.
  - On a pop, the next edge captures the word: `out_write <= 1`, `out_din <= slice gnt`, `out_id <= gnt`, `beats <= beats+1`.
  - Otherwise `out_write <= 0`, and `out_din`/`out_id` hold their values.
- GRANT exits to IDLE when either condition holds:
  - `in_empty_n[gnt]=0`, whatever the state of `out_full_n`; no pop occurs that cycle.
  - A pop occurs with `beats == MAX_BURST-1`.
- Backpressure (`out_full_n=0`) with a non-empty source holds the grant; `beats` is unchanged.
- `busy` = (state == GRANT).
- Downstream contract:
  - `out_full_n` is treated as almost-full.
  - The sink must absorb at least one write issued after `out_full_n` falls, so downstream GRACE_PERIOD must be ≥ 1.
- Reset (asynchronous, at any time, including mid-burst):
  - state=IDLE, `gnt=0`, `last=NUM_IN-1` (source 0 is first priority), `beats=0`.
  - `out_write=0`, `out_din=0`, `out_id=0`, `busy=0`, `in_read=0`.
  - A word captured before reset but not yet presented is dropped.
- NUM_IN=1: `gnt` is always 0; the burst limit still forces one IDLE cycle between bursts.

## Timing
- Arbitration latency: a source first seen valid in IDLE at cycle t → GRANT at t+1 → `in_read` at t+1 → `out_write`/`out_din` at t+2.
- Throughput:
  - Within a grant: one beat per cycle while the source is valid and `out_full_n=1`.
  - Each grant costs one IDLE bubble, so sustained rate under contention is MAX_BURST/(MAX_BURST+1).
- `in_read` is combinational from state, `gnt`, `in_empty_n` and `out_full_n`; no other input reaches it.
- All outputs except `in_read` come from flops.
- `out_write` follows `in_read` by exactly one cycle; data order per source is preserved.
- Fairness: a continuously requesting source waits at most (NUM_IN-1)*(MAX_BURST+1) cycles for its grant.

## Test plan
- **Single source.**
  - Stimulus: NUM_IN=4, MAX_BURST=4; only source 2 is valid, with 10 words 0..9.
  - Response: bursts of 4, 4 and 2 beats, each separated by one idle cycle. `out_id=2` throughout; data 0..9 in order. First `out_write` occurs 2 cycles after `in_empty_n[2]` rises.
- **Contention.**
  - Stimulus: all 4 sources always valid; MAX_BURST=2.
  - Response: `out_id` sequence 0,0,1,1,2,2,3,3,0,… with one idle cycle between pairs. No source starves.
- **Backpressure.**
  - Stimulus: hold `out_full_n=0` for 5 cycles during a grant.
  - Response: `in_read=0` and `out_write=0` one cycle later; the grant is held; `beats` is frozen. Transfer resumes with no loss or duplication when `out_full_n` returns high.
- **Source drains early.**
  - Stimulus: source 1 supplies 3 words with MAX_BURST=8.
  - Response: 3 beats, then `in_empty_n[1]=0` returns the block to IDLE. The next grant goes to the next valid source after 1.
- **Reset mid-burst.**
  - Stimulus: assert `reset` asynchronously, between clock edges, during beat 2 of a burst.
  - Response: `out_write`, `in_read`, `busy`, `out_din` and `out_id` go to 0 immediately. After release, with all sources valid, source 0 is granted first.
- **Degenerate configuration.**
  - Stimulus: NUM_IN=1, MAX_BURST=1.
  - Response: alternating pop and idle cycles; `out_id=0` on every word.

Source files
------------

// File: rtl/stream_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter_if
// Bundles the source-side FWFT streams and the downstream write port of the
// round-robin stream arbiter.
//   in_empty_n  per-source "word available" flags (FWFT valid)
//   in_read     per-source pop strobes, one-hot or zero
//   in_dout     concatenated source words, slice i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_full_n  downstream not-almost-full
//   out_write   registered write strobe to downstream
//   out_din     registered data word
//   out_id      registered source index of out_din
// Modport master is the arbiter's view; slave is the surrounding logic
// (sources plus downstream sink).
// The parameters must match the ones given to the arbiter instance.
// ---------------------------------------------------------------------------
interface stream_rr_arbiter_if #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
   logic [NUM_IN-1:0]            in_empty_n;
   logic [NUM_IN-1:0]            in_read;
   logic [NUM_IN*DATA_WIDTH-1:0] in_dout;
   logic                         out_full_n;
   logic                         out_write;
   logic [DATA_WIDTH-1:0]        out_din;
   logic [ID_WIDTH-1:0]          out_id;

   modport master (
      input  in_empty_n,
      input  in_dout,
      input  out_full_n,
      output in_read,
      output out_write,
      output out_din,
      output out_id
   );

   modport slave (
      output in_empty_n,
      output in_dout,
      output out_full_n,
      input  in_read,
      input  out_write,
      input  out_din,
      input  out_id
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
// Merges NUM_IN first-word fall-through source streams into one registered
// downstream write port. Sources are served round-robin, each grant moves at
// most MAX_BURST beats, and every output word carries its source index.
// Ports:
//   clk    single rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    stream_rr_arbiter_if.master (source streams + downstream port)
//   busy   high while a grant is active
// ---------------------------------------------------------------------------
module stream_rr_arbiter #(
   parameter int NUM_IN     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 8,
   parameter int ID_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                clk,
   input  logic                reset,
   stream_rr_arbiter_if.master bus,
   output logic                busy
);

   localparam int BEAT_WIDTH = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                state;
   logic [ID_WIDTH-1:0]   gnt;
   logic [ID_WIDTH-1:0]   last;
   logic [BEAT_WIDTH-1:0] beats;

   logic [ID_WIDTH-1:0]   next_gnt;
   logic                  found;
   logic                  gnt_valid;
   logic [DATA_WIDTH-1:0] gnt_data;
   logic                  pop;
   logic                  last_beat;

   // Round-robin pick: first search the sources above the most recent grant,
   // then wrap around and search from source 0 up to and including it. This
   // gives the order last+1, last+2, ... modulo NUM_IN without a modulo.
   always_comb begin
      found    = 1'b0;
      next_gnt = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (!found && bus.in_empty_n[i] && (ID_WIDTH'(i) > last)) begin
            found    = 1'b1;
            next_gnt = ID_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (!found && bus.in_empty_n[i]) begin
            found    = 1'b1;
            next_gnt = ID_WIDTH'(i);
         end
      end
   end

   // Mux out the valid flag and word of the granted source. Matching against
   // every legal index keeps this safe when NUM_IN is not a power of two.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_data  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (gnt == ID_WIDTH'(i)) begin
            gnt_valid = bus.in_empty_n[i];
            gnt_data  = bus.in_dout[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A beat moves only while granted, the granted source has a word and the
   // sink is not almost-full. The pop strobe is purely combinational so the
   // source sees it in the same cycle its word is sampled.
   assign pop       = (state == GRANT) && gnt_valid && bus.out_full_n;
   assign last_beat = (beats == BEAT_WIDTH'(MAX_BURST - 1));

   always_comb begin
      bus.in_read = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (pop && (gnt == ID_WIDTH'(i))) begin
            bus.in_read[i] = 1'b1;
         end
      end
   end

   // Arbitration state machine plus the registered output stage. IDLE spends
   // exactly one cycle choosing the next source; GRANT streams beats until the
   // source runs dry or the burst budget is used up. Reset makes source 0 the
   // first in line by pretending the last grant went to NUM_IN-1, and drops
   // any word sitting in the output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         gnt           <= '0;
         last          <= ID_WIDTH'(NUM_IN - 1);
         beats         <= '0;
         bus.out_write <= 1'b0;
         bus.out_din   <= '0;
         bus.out_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.out_write <= 1'b0;
               if (|bus.in_empty_n) begin
                  gnt   <= next_gnt;
                  last  <= next_gnt;
                  beats <= '0;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (pop) begin
                  bus.out_write <= 1'b1;
                  bus.out_din   <= gnt_data;
                  bus.out_id    <= gnt;
                  beats         <= beats + BEAT_WIDTH'(1);
                  if (last_beat) begin
                     state <= IDLE;
                  end
               end else begin
                  bus.out_write <= 1'b0;
                  if (!gnt_valid) begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Randomized, scoreboard-based bench for stream_rr_arbiter. A 4-source,
// burst-4 instance is driven from per-source word queues; a 1-source,
// burst-1 instance runs alongside for the degenerate configuration.
// ---------------------------------------------------------------------------
module tb_stream_rr_arbiter;

   localparam int NUM_IN    = 4;
   localparam int DW        = 32;
   localparam int MAX_BURST = 4;
   localparam int IDW       = 2;

   localparam int M_SINGLE  = 0;
   localparam int M_CONTEND = 1;
   localparam int M_BACKP   = 2;
   localparam int M_RANDOM  = 3;
   localparam int M_DRAIN   = 4;

   typedef struct {
      int            cyc;
      int            id;
      logic [DW-1:0] data;
   } exp_t;

   logic clk;
   logic reset;
   logic busy;
   logic degBusy;

   stream_rr_arbiter_if #(.NUM_IN(NUM_IN), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();
   stream_rr_arbiter_if #(.NUM_IN(1), .DATA_WIDTH(DW), .ID_WIDTH(1)) degBus ();

   stream_rr_arbiter #(
      .NUM_IN(NUM_IN), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST), .ID_WIDTH(IDW)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy)
   );

   stream_rr_arbiter #(
      .NUM_IN(1), .DATA_WIDTH(DW), .MAX_BURST(1), .ID_WIDTH(1)
   ) degDut (
      .clk(clk), .reset(reset), .bus(degBus), .busy(degBusy)
   );

   int            compared   = 0;
   int            mismatched = 0;
   int            cycle      = 0;
   int            mode       = M_SINGLE;
   logic [DW-1:0] srcQ[NUM_IN][$];
   int            seq[NUM_IN];
   bit            srcEn[NUM_IN];
   bit            fullN;
   logic [NUM_IN-1:0] readMask;
   exp_t          expQ[$];

   // Reference model: who holds the grant (-1 while choosing), who was served
   // last and how many beats the holder has moved so far.
   int            mHolder;
   int            mLast;
   int            mUsed;

   logic [DW-1:0] degData;
   bit            degSeen;

   assign degBus.in_empty_n = 1'b1;
   assign degBus.out_full_n = 1'b1;
   assign degBus.in_dout    = degData;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic bit bitAt(input logic [NUM_IN-1:0] v, input int idx);
      logic [NUM_IN-1:0] t;
      t = v >> idx;
      return t[0];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
      end
   endtask

   task automatic pushWord(input int i);
      srcQ[i].push_back({8'(i + 1), 24'(seq[i])});
      seq[i]++;
   endtask

   // One cycle of the reference model, evaluated at the falling edge once all
   // inputs are settled. Expected pops are checked against in_read directly;
   // the word each pop should deliver is queued for the output monitor.
   task automatic modelStep();
      logic [NUM_IN-1:0] vld;
      logic [NUM_IN-1:0] expRead;
      bit                expBusy;
      exp_t              e;
      vld     = bus.in_empty_n;
      expRead = '0;
      expBusy = (mHolder >= 0);
      if (mHolder < 0) begin
         if (vld != '0) begin
            for (int k = 1; k <= NUM_IN; k++) begin
               if (mHolder < 0 && bitAt(vld, (mLast + k) % NUM_IN)) mHolder = (mLast + k) % NUM_IN;
            end
            mLast = mHolder;
            mUsed = 0;
         end
      end else if (!bitAt(vld, mHolder)) begin
         mHolder = -1;
      end else if (fullN) begin
         expRead = NUM_IN'(1) << mHolder;
         e.cyc   = cycle;
         e.id    = mHolder;
         e.data  = srcQ[mHolder][0];
         expQ.push_back(e);
         mUsed++;
         if (mUsed == MAX_BURST) mHolder = -1;
      end
      checkOutput("in_read", 64'(bus.in_read), 64'(expRead));
      checkOutput("busy", 64'(busy), 64'(expBusy));
      readMask = bus.in_read;
   endtask

   // Just after the rising edge: retire the words the arbiter popped, refill
   // and re-enable sources according to the current traffic mode, and drive
   // the new FWFT view of every source.
   task automatic popAndDrive();
      logic [NUM_IN*DW-1:0] dout;
      logic [NUM_IN-1:0]    vldVec;
      for (int i = 0; i < NUM_IN; i++) begin
         if (bitAt(readMask, i) && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
      end
      for (int i = 0; i < NUM_IN; i++) begin
         case (mode)
            M_SINGLE: srcEn[i] = (i == 2);
            M_RANDOM: srcEn[i] = ($urandom_range(0, 3) != 0);
            default:  srcEn[i] = 1'b1;
         endcase
         if ((mode == M_CONTEND || mode == M_BACKP) && srcQ[i].size() < 3) pushWord(i);
         if (mode == M_RANDOM && srcQ[i].size() < 4 && $urandom_range(0, 1) == 1) pushWord(i);
      end
      case (mode)
         M_BACKP:  fullN = ((cycle % 12) >= 5);
         M_RANDOM: fullN = ($urandom_range(0, 3) != 0);
         default:  fullN = 1'b1;
      endcase
      dout   = '0;
      vldVec = '0;
      for (int i = NUM_IN - 1; i >= 0; i--) begin
         dout   = dout << DW;
         vldVec = vldVec << 1;
         if (srcEn[i] && srcQ[i].size() > 0) begin
            vldVec[0]      = 1'b1;
            dout[DW-1:0]   = srcQ[i][0];
         end
      end
      bus.in_empty_n = vldVec;
      bus.in_dout    = dout;
      bus.out_full_n = fullN;
   endtask

   task automatic applyStimulus(input int nCycles);
      for (int n = 0; n < nCycles; n++) begin
         @(negedge clk);
         modelStep();
         @(posedge clk);
         #1;
         popAndDrive();
      end
   endtask

   // Called just after a rising edge; asserts reset between edges and checks
   // that every registered and combinational output clears immediately.
   task automatic applyReset();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst_out_write", 64'(bus.out_write), 64'(0));
      checkOutput("rst_in_read", 64'(bus.in_read), 64'(0));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_out_din", 64'(bus.out_din), 64'(0));
      checkOutput("rst_out_id", 64'(bus.out_id), 64'(0));
      expQ.delete();
      mHolder = -1;
      mLast   = NUM_IN - 1;
      mUsed   = 0;
      @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   // Degenerate instance right after reset release: IDLE and GRANT alternate,
   // so pops land on odd cycles and writes follow one cycle later.
   task automatic degenCheck(input int n);
      logic [DW-1:0] popped;
      bit            prevRead;
      popped   = '0;
      prevRead = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         checkOutput("deg_in_read", 64'(degBus.in_read), 64'((k % 2) == 1));
         checkOutput("deg_out_write", 64'(degBus.out_write), 64'(prevRead));
         if (prevRead) begin
            checkOutput("deg_out_id", 64'(degBus.out_id), 64'(0));
            checkOutput("deg_out_din", 64'(degBus.out_din), 64'(popped));
         end
         prevRead = ((k % 2) == 1);
         popped   = degData;
      end
   endtask

   // Degenerate source: an endless counter that advances on every pop.
   initial begin
      degData = 32'h0000_0100;
      forever begin
         @(negedge clk);
         degSeen = degBus.in_read[0] && !reset;
         @(posedge clk);
         #1;
         if (degSeen && !reset) degData = degData + 1;
      end
   end

   // Output monitor: every write must match the oldest expected word, and
   // must appear exactly one cycle after the pop that produced it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.out_write) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_write", 64'(1), 64'(0));
               end else begin
                  e = expQ.pop_front();
                  checkOutput("write_latency", 64'(cycle), 64'(e.cyc + 1));
                  checkOutput("out_id", 64'(bus.out_id), 64'(e.id));
                  checkOutput("out_din", 64'(bus.out_din), 64'(e.data));
               end
            end else if (expQ.size() > 0 && expQ[0].cyc < cycle) begin
               checkOutput("missing_write", 64'(0), 64'(1));
               void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      int  g;
      bit  pending;
      reset          = 1'b1;
      bus.in_empty_n = '0;
      bus.in_dout    = '0;
      bus.out_full_n = 1'b1;
      fullN          = 1'b1;
      readMask       = '0;
      mHolder        = -1;
      mLast          = NUM_IN - 1;
      mUsed          = 0;
      for (int i = 0; i < NUM_IN; i++) begin
         seq[i]   = 0;
         srcEn[i] = 1'b0;
      end

      #12;
      checkOutput("init_busy", 64'(busy), 64'(0));
      checkOutput("init_out_write", 64'(bus.out_write), 64'(0));
      checkOutput("init_in_read", 64'(bus.in_read), 64'(0));
      checkOutput("init_out_din", 64'(bus.out_din), 64'(0));
      checkOutput("init_out_id", 64'(bus.out_id), 64'(0));
      @(posedge clk);
      #3;
      reset = 1'b0;

      $display("[TB] single source: source 2 with words 0..9");
      for (int k = 0; k < 10; k++) srcQ[2].push_back(DW'(k));
      mode = M_SINGLE;
      applyStimulus(25);

      $display("[TB] early drain: short queues, no refill");
      for (int k = 0; k < 3; k++) pushWord(1);
      for (int k = 0; k < 4; k++) pushWord(3);
      for (int k = 0; k < 2; k++) pushWord(0);
      mode = M_DRAIN;
      applyStimulus(25);

      $display("[TB] contention: all sources always valid");
      mode = M_CONTEND;
      applyStimulus(30);

      $display("[TB] backpressure windows");
      mode = M_BACKP;
      applyStimulus(48);

      $display("[TB] randomized traffic");
      mode = M_RANDOM;
      applyStimulus(400);

      $display("[TB] reset in the middle of a burst");
      mode = M_CONTEND;
      for (g = 0; g < 50 && !(mHolder >= 0 && mUsed == 2); g++) applyStimulus(1);
      checkOutput("reach_mid_burst", 64'(mHolder >= 0 && mUsed == 2), 64'(1));
      applyReset();
      fork
         applyStimulus(30);
         degenCheck(12);
      join

      mode = M_RANDOM;
      applyStimulus(100);

      mode    = M_DRAIN;
      pending = 1'b1;
      for (g = 0; g < 500 && pending; g++) begin
         applyStimulus(1);
         pending = (expQ.size() > 0);
         for (int i = 0; i < NUM_IN; i++) if (srcQ[i].size() > 0) pending = 1'b1;
      end
      applyStimulus(3);
      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
